// File: rtl/note_pkg.sv
// Shared types, note constants and pitch tables for the melody sequencer.
// Half-period values are derived at elaboration from the system clock rate.
package note_pkg;

  localparam int NOTE_W    = 5;
  localparam int DUR_W     = 4;
  localparam int ENTRY_W   = NOTE_W + DUR_W;
  localparam int SONG_LEN  = 16;
  localparam int IDX_W     = 4;
  localparam int HP_W      = 16;
  localparam int NUM_NOTES = 24;

  typedef logic [SONG_LEN-1:0][ENTRY_W-1:0]     song_t;
  typedef logic [(1<<NOTE_W)-1:0][HP_W-1:0]     hp_table_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } seq_state_e;

  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
  localparam logic [NOTE_W-1:0] NOTE_C4  = 5'd1,  NOTE_CS4 = 5'd2,  NOTE_D4  = 5'd3,  NOTE_DS4 = 5'd4;
  localparam logic [NOTE_W-1:0] NOTE_E4  = 5'd5,  NOTE_F4  = 5'd6,  NOTE_FS4 = 5'd7,  NOTE_G4  = 5'd8;
  localparam logic [NOTE_W-1:0] NOTE_GS4 = 5'd9,  NOTE_A4  = 5'd10, NOTE_AS4 = 5'd11, NOTE_B4  = 5'd12;
  localparam logic [NOTE_W-1:0] NOTE_C5  = 5'd13, NOTE_CS5 = 5'd14, NOTE_D5  = 5'd15, NOTE_DS5 = 5'd16;
  localparam logic [NOTE_W-1:0] NOTE_E5  = 5'd17, NOTE_F5  = 5'd18, NOTE_FS5 = 5'd19, NOTE_G5  = 5'd20;
  localparam logic [NOTE_W-1:0] NOTE_GS5 = 5'd21, NOTE_A5  = 5'd22, NOTE_AS5 = 5'd23, NOTE_B5  = 5'd24;

  // Pitch in Hz*100, index = note code (entry 0 unused: rest)
  localparam int FREQ_MUL100 [NUM_NOTES+1] = '{
    0,
    26163, 27718, 29366, 31113, 32963, 34923, 36999, 39200, 41530, 44000, 46616, 49388,
    52325, 55437, 58733, 62225, 65926, 69846, 73999, 78399, 83061, 88000, 93233, 98777
  };

  function automatic logic [HP_W-1:0] half_period(input longint clk_hz, input int code);
    if (code < 1 || code > NUM_NOTES) return '0;
    return HP_W'((clk_hz * 100) / (2 * longint'(FREQ_MUL100[code])));
  endfunction

  function automatic hp_table_t build_hp_table(input longint clk_hz);
    hp_table_t t;
    t = '0;
    for (int c = 1; c <= NUM_NOTES; c++) t[c] = half_period(clk_hz, c);
    return t;
  endfunction

  function automatic logic [ENTRY_W-1:0] note_entry(input logic [NOTE_W-1:0] code,
                                                   input logic [DUR_W-1:0]  dur);
    return {code, dur};
  endfunction

  // Twinkle Twinkle, entry 0 is the rightmost element
  localparam song_t DEFAULT_SONG = {
    note_entry(NOTE_REST, 4'd0), note_entry(NOTE_REST, 4'd2),
    note_entry(NOTE_C4, 4'd4),   note_entry(NOTE_D4, 4'd2),
    note_entry(NOTE_D4, 4'd2),   note_entry(NOTE_E4, 4'd2),
    note_entry(NOTE_E4, 4'd2),   note_entry(NOTE_F4, 4'd2),
    note_entry(NOTE_F4, 4'd2),   note_entry(NOTE_G4, 4'd4),
    note_entry(NOTE_A4, 4'd2),   note_entry(NOTE_A4, 4'd2),
    note_entry(NOTE_G4, 4'd2),   note_entry(NOTE_G4, 4'd2),
    note_entry(NOTE_C4, 4'd2),   note_entry(NOTE_C4, 4'd2)
  };

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to the tempo tick: one-cycle pulse per period.
// clear_i holds the phase at zero so the first tick lands one full period later.
module tick_prescaler #(
  parameter int clock_frequency = 12000000,
  parameter int tick_hz         = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int DIV = clock_frequency / tick_hz;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          tick_q;
  logic          terminal;

  assign terminal = (cnt_q == CW'(DIV - 1));
  assign tick_o   = tick_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= terminal ? '0 : cnt_q + CW'(1);
      tick_q <= terminal;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer: walks the song table and feeds the square-wave generator
// a half-period with a reload strobe, plus a gate for rests and articulation gaps.
module note_sequencer
  import note_pkg::*;
#(
  parameter int    clock_frequency = 12000000,
  parameter int    tick_hz         = 16,
  parameter bit    loop_song       = 1'b1,
  parameter song_t song            = DEFAULT_SONG
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic            stop_i,
  output logic [HP_W-1:0] half_period_o,
  output logic            note_valid_o,
  output logic            gate_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam hp_table_t HP_TAB = build_hp_table(longint'(clock_frequency));

  seq_state_e         state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [HP_W-1:0]    half_period_q, half_period_d;
  logic               note_valid_q, note_valid_d;
  logic               gate_q, gate_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tick;

  logic [NOTE_W-1:0]  cur_note;
  logic [DUR_W-1:0]   cur_dur;
  logic               cur_sounds;

  assign cur_note   = song[index_q][ENTRY_W-1:DUR_W];
  assign cur_dur    = song[index_q][DUR_W-1:0];
  // Codes beyond the chromatic range play as rests
  assign cur_sounds = (cur_note != '0) && (cur_note <= NOTE_W'(NUM_NOTES));

  tick_prescaler #(
    .clock_frequency(clock_frequency),
    .tick_hz        (tick_hz)
  ) u_prescaler (
    .clock  (clock),
    .reset_n(reset_n),
    .clear_i(state_q == ST_IDLE),
    .tick_o (tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      index_q       <= '0;
      dur_q         <= '0;
      half_period_q <= '0;
      note_valid_q  <= 1'b0;
      gate_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      dur_q         <= dur_d;
      half_period_q <= half_period_d;
      note_valid_q  <= note_valid_d;
      gate_q        <= gate_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // dur_q holds the ticks still to play before the articulation gap
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    dur_d   = dur_q;
    if (stop_i) begin
      state_d = ST_IDLE;
      index_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          index_d = '0;
          if (start_i) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          if (cur_dur == '0) begin
            index_d = '0;
            state_d = loop_song ? ST_LOAD : ST_IDLE;
          end else begin
            dur_d   = cur_dur - DUR_W'(1);
            state_d = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (dur_q == '0) begin
            state_d = ST_GAP;
          end else if (tick) begin
            dur_d = dur_q - DUR_W'(1);
            if (dur_q == DUR_W'(1)) state_d = ST_GAP;
          end
        end
        ST_GAP: begin
          if (tick) begin
            index_d = index_q + IDX_W'(1);
            state_d = ST_LOAD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    half_period_d = half_period_q;
    note_valid_d  = 1'b0;
    gate_d        = gate_q;
    done_d        = 1'b0;
    busy_d        = (state_d != ST_IDLE);
    if (stop_i) begin
      gate_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: gate_d = 1'b0;
        ST_LOAD: begin
          if (cur_dur == '0) begin
            done_d = 1'b1;
            gate_d = 1'b0;
          end else begin
            gate_d = cur_sounds;
            if (cur_sounds) begin
              half_period_d = HP_TAB[cur_note];
              note_valid_d  = 1'b1;
            end
          end
        end
        ST_PLAY: if (state_d == ST_GAP) gate_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign half_period_o = half_period_q;
  assign note_valid_o  = note_valid_q;
  assign gate_o        = gate_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench: three sequencer instances (single note, rests, looping song).
// Stimulus pushes expected output events; a negedge monitor pops and compares them.
module tb_note_sequencer;
  import note_pkg::*;

  typedef enum int {EV_BUSY_RISE, EV_BUSY_FALL, EV_NV, EV_GATE_RISE, EV_GATE_FALL,
                    EV_DONE, EV_HP} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int          cyc;
    logic [15:0] hp;
  } ev_t;

  localparam song_t SONG_A = {{14{9'd0}}, 9'd0, note_entry(NOTE_A4, 4'd3)};
  localparam song_t SONG_B = {{12{9'd0}}, 9'd0, note_entry(NOTE_C4, 4'd2),
                              note_entry(NOTE_REST, 4'd2), note_entry(NOTE_C4, 4'd2)};
  localparam song_t SONG_C = {{13{9'd0}}, 9'd0, note_entry(NOTE_C4, 4'd2),
                              note_entry(NOTE_A4, 4'd2)};

  logic        clock = 1'b0;
  logic        rst_n [3];
  logic        start_s [3];
  logic        stop_s [3];
  logic [15:0] hp [3];
  logic        nv [3];
  logic        gate [3];
  logic        busy [3];
  logic        done [3];

  logic [15:0] hp_p [3];
  logic        gate_p [3];
  logic        busy_p [3];

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q [3][$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  note_sequencer #(.clock_frequency(1000), .tick_hz(100), .loop_song(1'b0), .song(SONG_A)) dut_a (
    .clock(clock), .reset_n(rst_n[0]), .start_i(start_s[0]), .stop_i(stop_s[0]),
    .half_period_o(hp[0]), .note_valid_o(nv[0]), .gate_o(gate[0]), .busy_o(busy[0]), .done_o(done[0]));

  note_sequencer #(.clock_frequency(20000), .tick_hz(2000), .loop_song(1'b0), .song(SONG_B)) dut_b (
    .clock(clock), .reset_n(rst_n[1]), .start_i(start_s[1]), .stop_i(stop_s[1]),
    .half_period_o(hp[1]), .note_valid_o(nv[1]), .gate_o(gate[1]), .busy_o(busy[1]), .done_o(done[1]));

  note_sequencer #(.clock_frequency(20000), .tick_hz(2000), .loop_song(1'b1), .song(SONG_C)) dut_c (
    .clock(clock), .reset_n(rst_n[2]), .start_i(start_s[2]), .stop_i(stop_s[2]),
    .half_period_o(hp[2]), .note_valid_o(nv[2]), .gate_o(gate[2]), .busy_o(busy[2]), .done_o(done[2]));

  task automatic got(input int k, input ev_kind_e kind, input logic [15:0] h);
    ev_t e;
    checks++;
    if (exp_q[k].size() == 0) begin
      failures++;
      $display("FAIL dut%0d unexpected event %s at cycle %0d hp=%0d", k, kind.name(), cyc, h);
    end else begin
      e = exp_q[k].pop_front();
      if (e.kind != kind || e.cyc != cyc || ((kind == EV_NV || kind == EV_HP) && e.hp != h)) begin
        failures++;
        $display("FAIL dut%0d event: got %s cyc=%0d hp=%0d, want %s cyc=%0d hp=%0d",
                 k, kind.name(), cyc, h, e.kind.name(), e.cyc, e.hp);
      end
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (busy[k] != busy_p[k]) got(k, busy[k] ? EV_BUSY_RISE : EV_BUSY_FALL, 16'd0);
        if (nv[k]) got(k, EV_NV, hp[k]);
        if (gate[k] != gate_p[k]) got(k, gate[k] ? EV_GATE_RISE : EV_GATE_FALL, 16'd0);
        if (done[k]) got(k, EV_DONE, 16'd0);
        if (hp[k] != hp_p[k] && !nv[k]) got(k, EV_HP, hp[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      busy_p[k] <= busy[k];
      gate_p[k] <= gate[k];
      hp_p[k]   <= hp[k];
    end
  end

  task automatic ex(input int k, input ev_kind_e kind, input int c, input logic [15:0] h = 16'd0);
    exp_q[k].push_back('{kind, c, h});
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse(input int k, input bit do_start, input bit do_stop, input int c);
    at_cyc(c);
    start_s[k] = do_start;
    stop_s[k]  = do_stop;
    at_cyc(c + 1);
    start_s[k] = 1'b0;
    stop_s[k]  = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  function automatic int outs(input int k);
    return int'({hp[k], nv[k], gate[k], busy[k], done[k]});
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b1; start_s[k] = 1'b0; stop_s[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
    at_cyc(3);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    at_cyc(4);
    mon_en = 1'b1;

    // Reset sanity: idle outputs stay zero, monitor sees nothing
    at_cyc(100);
    chk("reset_a_outputs", outs(0), 0);
    chk("reset_b_outputs", outs(1), 0);
    chk("reset_c_outputs", outs(2), 0);

    // Single note A4 d=3, start at 110
    ex(0, EV_BUSY_RISE, 111); ex(0, EV_NV, 112, 16'd1); ex(0, EV_GATE_RISE, 112);
    ex(0, EV_GATE_FALL, 132); ex(0, EV_BUSY_FALL, 143); ex(0, EV_DONE, 143);
    pulse(0, 1'b1, 1'b0, 110);

    // Rest handling: C4 2, rest 2, C4 2, end
    ex(1, EV_BUSY_RISE, 201); ex(1, EV_NV, 202, 16'd38); ex(1, EV_GATE_RISE, 202);
    ex(1, EV_GATE_FALL, 212);
    ex(1, EV_NV, 243, 16'd38); ex(1, EV_GATE_RISE, 243); ex(1, EV_GATE_FALL, 252);
    ex(1, EV_BUSY_FALL, 263); ex(1, EV_DONE, 263);
    pulse(1, 1'b1, 1'b0, 200);
    at_cyc(230);
    chk("rest_hp_held", int'(hp[1]), 38);
    chk("rest_gate_low", int'(gate[1]), 0);
    chk("rest_busy", int'(busy[1]), 1);

    // start+stop together while idle: stop wins
    pulse(1, 1'b1, 1'b1, 280);
    at_cyc(285);
    chk("start_stop_idle_busy", int'(busy[1]), 0);

    // Looping two-note song; start while busy ignored; stop at 390
    ex(2, EV_BUSY_RISE, 301); ex(2, EV_NV, 302, 16'd22); ex(2, EV_GATE_RISE, 302);
    ex(2, EV_GATE_FALL, 312); ex(2, EV_NV, 323, 16'd38); ex(2, EV_GATE_RISE, 323);
    ex(2, EV_GATE_FALL, 332); ex(2, EV_DONE, 343);
    ex(2, EV_NV, 344, 16'd22); ex(2, EV_GATE_RISE, 344); ex(2, EV_GATE_FALL, 352);
    ex(2, EV_NV, 363, 16'd38); ex(2, EV_GATE_RISE, 363); ex(2, EV_GATE_FALL, 372);
    ex(2, EV_DONE, 383); ex(2, EV_NV, 384, 16'd22); ex(2, EV_GATE_RISE, 384);
    ex(2, EV_BUSY_FALL, 391); ex(2, EV_GATE_FALL, 391);
    pulse(2, 1'b1, 1'b0, 300);
    pulse(2, 1'b1, 1'b0, 370);
    pulse(2, 1'b0, 1'b1, 390);

    // Stop mid-note then replay from entry 0
    ex(0, EV_BUSY_RISE, 401); ex(0, EV_NV, 402, 16'd1); ex(0, EV_GATE_RISE, 402);
    ex(0, EV_BUSY_FALL, 416); ex(0, EV_GATE_FALL, 416);
    pulse(0, 1'b1, 1'b0, 400);
    pulse(0, 1'b0, 1'b1, 415);
    at_cyc(418);
    chk("stop_hp_held", int'(hp[0]), 1);
    chk("stop_busy_low", int'(busy[0]), 0);
    ex(0, EV_BUSY_RISE, 421); ex(0, EV_NV, 422, 16'd1); ex(0, EV_GATE_RISE, 422);
    ex(0, EV_GATE_FALL, 442); ex(0, EV_BUSY_FALL, 453); ex(0, EV_DONE, 453);
    pulse(0, 1'b1, 1'b0, 420);

    // Reset mid-note clears outputs immediately
    ex(1, EV_BUSY_RISE, 501); ex(1, EV_NV, 502, 16'd38); ex(1, EV_GATE_RISE, 502);
    ex(1, EV_BUSY_FALL, 510); ex(1, EV_GATE_FALL, 510); ex(1, EV_HP, 510, 16'd0);
    pulse(1, 1'b1, 1'b0, 500);
    at_cyc(510);
    rst_n[1] = 1'b0;
    at_cyc(513);
    rst_n[1] = 1'b1;
    at_cyc(515);
    chk("reset_mid_note_outputs", outs(1), 0);

    at_cyc(600);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        failures++;
        $display("FAIL dut%0d missing %0d events, first %s at cycle %0d",
                 k, exp_q[k].size(), exp_q[k][0].kind.name(), exp_q[k][0].cyc);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
